// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported memory between instruction fetch (read-only) and load/store.
// Fixed LS priority with IF aging by default; define MEM_ARB_RR_EN for round-robin arbitration.
module mem_port_arbiter #(
  parameter int unsigned N        = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         if_req,
  input  logic [N-1:0] if_addr,
  output logic         if_gnt,
  output logic         if_rvalid,
  output logic [N-1:0] if_rdata,
  input  logic         ls_req,
  input  logic         ls_we,
  input  logic [N-1:0] ls_addr,
  input  logic [N-1:0] ls_wdata,
  output logic         ls_gnt,
  output logic         ls_rvalid,
  output logic [N-1:0] ls_rdata,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic         mem_we,
  input  logic [N-1:0] mem_rdata
);

  logic         if_rvalid_q, if_rvalid_d;
  logic         ls_rvalid_q, ls_rvalid_d;
  logic [N-1:0] if_rdata_q, if_rdata_d;
  logic [N-1:0] ls_rdata_q, ls_rdata_d;

`ifdef MEM_ARB_RR_EN
  typedef enum logic {GNT_IF = 1'b0, GNT_LS = 1'b1} gnt_e;

  gnt_e last_gnt_q, last_gnt_d;

  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (rst_n) begin
      if (if_req && ls_req) begin
        if (last_gnt_q == GNT_LS) if_gnt = 1'b1;
        else                      ls_gnt = 1'b1;
      end else begin
        if_gnt = if_req;
        ls_gnt = ls_req;
      end
    end
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (if_gnt)      last_gnt_d = GNT_IF;
    else if (ls_gnt) last_gnt_d = GNT_LS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_gnt_q <= GNT_IF;
    else        last_gnt_q <= last_gnt_d;
  end
`else
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (rst_n) begin
      if (if_req && ls_req) begin
        if (wait_cnt_q == MAX_WAIT_C) if_gnt = 1'b1;
        else                          ls_gnt = 1'b1;
      end else begin
        if_gnt = if_req;
        ls_gnt = ls_req;
      end
    end
  end

  // Counts consecutive denied IF cycles; saturates so the forced IF win is sticky until taken.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!if_req || if_gnt)            wait_cnt_d = '0;
    else if (wait_cnt_q < MAX_WAIT_C) wait_cnt_d = wait_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end
`endif

  // With no grant the port idles on the IF address so a fetch read is already in flight.
  always_comb begin
    mem_addr  = if_addr;
    mem_wdata = '0;
    if (ls_gnt) begin
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end
  end

  assign mem_we = ls_gnt & ls_we;

  always_comb begin
    if_rvalid_d = if_gnt;
    ls_rvalid_d = ls_gnt;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if (if_gnt) if_rdata_d = mem_rdata;
    if (ls_gnt) ls_rdata_d = ls_we ? '0 : mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign ls_rvalid = ls_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a behavioural model.
// Memory is a word array indexed by address bits [9:2].
module tb_mem_port_arbiter;
  localparam int unsigned N        = 32;
  localparam int unsigned MAX_WAIT = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         if_req, if_gnt, if_rvalid;
  logic [N-1:0] if_addr, if_rdata;
  logic         ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [N-1:0] ls_addr, ls_wdata, ls_rdata;
  logic [N-1:0] mem_addr, mem_wdata, mem_rdata;
  logic         mem_we;

  always #5 clk = ~clk;

  mem_port_arbiter #(.N(N), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  logic [31:0] mem [256];
  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [31:0] bd_data;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (bd_we)       mem[bd_addr] <= bd_data;
    else if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  logic [31:0] ref_mem [256];
  int unsigned starve;
  bit          last_ls;
  bit          exp_if_rv, exp_ls_rv;
  logic [31:0] exp_if_rd, exp_ls_rd;
  bit          g_if, g_ls;
  bit          obs_if_gnt, obs_ls_gnt;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    starve    = 0;
    last_ls   = 1'b0;
    exp_if_rv = 1'b0;
    exp_ls_rv = 1'b0;
    exp_if_rd = '0;
    exp_ls_rd = '0;
  endtask

  // Called just after a negedge with inputs already applied; returns at the next negedge.
  task automatic cycle();
    #1;
    g_if = 1'b0;
    g_ls = 1'b0;
    if (if_req && ls_req) begin
`ifdef MEM_ARB_RR_EN
      if (last_ls) g_if = 1'b1;
      else         g_ls = 1'b1;
`else
      if (starve >= MAX_WAIT) g_if = 1'b1;
      else                    g_ls = 1'b1;
`endif
    end else begin
      g_if = if_req;
      g_ls = ls_req;
    end
    obs_if_gnt = if_gnt;
    obs_ls_gnt = ls_gnt;
    chk("if_gnt", 32'(if_gnt), 32'(g_if));
    chk("ls_gnt", 32'(ls_gnt), 32'(g_ls));
    chk("mem_we", 32'(mem_we), 32'(g_ls && ls_we));
    if (g_ls) chk("mem_addr_ls", mem_addr, ls_addr);
    else      chk("mem_addr_if", mem_addr, if_addr);
    if (g_ls && ls_we) chk("mem_wdata", mem_wdata, ls_wdata);
    @(posedge clk);
    exp_if_rv = g_if;
    exp_ls_rv = g_ls;
    if (g_if) exp_if_rd = ref_mem[if_addr[9:2]];
    if (g_ls) begin
      if (ls_we) begin
        exp_ls_rd = '0;
        ref_mem[ls_addr[9:2]] = ls_wdata;
      end else begin
        exp_ls_rd = ref_mem[ls_addr[9:2]];
      end
    end
    if (!if_req || g_if)      starve = 0;
    else if (starve < MAX_WAIT) starve++;
    if (g_if)      last_ls = 1'b0;
    else if (g_ls) last_ls = 1'b1;
    #1;
    chk("if_rvalid", 32'(if_rvalid), 32'(exp_if_rv));
    chk("ls_rvalid", 32'(ls_rvalid), 32'(exp_ls_rv));
    chk("if_rdata", if_rdata, exp_if_rd);
    chk("ls_rdata", ls_rdata, exp_ls_rd);
    @(negedge clk);
  endtask

  task automatic new_if();
    if_req  = ($urandom_range(0, 3) != 0);
    if_addr = {22'b0, 8'($urandom), 2'b00};
  endtask

  task automatic new_ls();
    ls_req   = ($urandom_range(0, 2) != 0);
    ls_we    = $urandom_range(0, 1) == 1;
    ls_addr  = {22'b0, 8'($urandom), 2'b00};
    ls_wdata = $urandom;
  endtask

  initial begin
    rst_n = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
    model_reset();
    @(negedge clk);

    // Reset holds everything quiet even with both requesters active.
    if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b1;
    if_addr = 32'h100; ls_addr = 32'h200; ls_wdata = 32'h5555_AAAA;
    #1;
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_ls_gnt", 32'(ls_gnt), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    for (int i = 0; i < 256; i++) begin
      bd_we   = 1'b1;
      bd_addr = 8'(i);
      bd_data = (i == 8'h40) ? 32'hDEAD_BEEF : $urandom;
      ref_mem[i] = bd_data;
      @(negedge clk);
    end
    bd_we = 1'b0;
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_ls_rvalid", 32'(ls_rvalid), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    chk("rst_mem_we2", 32'(mem_we), 32'd0);
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    rst_n = 1'b1;
    model_reset();

    // IF-only fetch.
    if_req = 1'b1; if_addr = 32'h100;
    cycle();
    chk("t2_if_gnt", 32'(obs_if_gnt), 32'd1);
    chk("t2_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("t2_if_rdata", if_rdata, 32'hDEAD_BEEF);

    // Store then load of the same address.
    if_req = 1'b0;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'h1234_5678;
    cycle();
    chk("t3_store_ack", 32'(ls_rvalid), 32'd1);
    chk("t3_store_rdata", ls_rdata, 32'd0);
    ls_we = 1'b0;
    cycle();
    chk("t3_load_rvalid", 32'(ls_rvalid), 32'd1);
    chk("t3_load_rdata", ls_rdata, 32'h1234_5678);
    ls_req = 1'b0;
    cycle();
    chk("t3_idle_rvalid", 32'(ls_rvalid), 32'd0);

    // Fetch of an address stored in the previous cycle sees the new data.
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h300; ls_wdata = 32'hA5A5_5A5A;
    cycle();
    ls_req = 1'b0; ls_we = 1'b0;
    if_req = 1'b1; if_addr = 32'h300;
    cycle();
    chk("fwd_if_rdata", if_rdata, 32'hA5A5_5A5A);
    if_req = 1'b0;
    cycle();

`ifndef MEM_ARB_RR_EN
    // Sustained contention: LS four times, forced IF, then LS again.
    if_req = 1'b1; if_addr = 32'h104;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h208;
    for (int c = 0; c < 6; c++) begin
      cycle();
      chk("t4_if_gnt", 32'(obs_if_gnt), 32'(c == 4));
      chk("t4_ls_gnt", 32'(obs_ls_gnt), 32'(c != 4));
    end
    if_req = 1'b0; ls_req = 1'b0;
    cycle();
`else
    // Round-robin from reset: LS, IF, LS, IF.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    if_req = 1'b1; if_addr = 32'h104;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h208;
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("t5_ls_gnt", 32'(obs_ls_gnt), 32'((c % 2) == 0));
      chk("t5_if_gnt", 32'(obs_if_gnt), 32'((c % 2) == 1));
    end
    if_req = 1'b0; ls_req = 1'b0;
    cycle();
`endif

    // Reset during a granted load aborts it.
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100;
    #1;
    chk("t6_ls_gnt", 32'(ls_gnt), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_gnt_rst", 32'(ls_gnt), 32'd0);
    @(posedge clk);
    #1;
    chk("t6_ls_rvalid", 32'(ls_rvalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ls_req = 1'b0;
    model_reset();
    cycle();
    chk("t6_ls_rvalid_after", 32'(ls_rvalid), 32'd0);

    // Random traffic: a pending request holds its fields until granted, or is occasionally dropped.
    new_if();
    new_ls();
    for (int n = 0; n < 600; n++) begin
      cycle();
      if (!if_req || g_if || $urandom_range(0, 7) == 0) new_if();
      if (!ls_req || g_ls || $urandom_range(0, 7) == 0) new_ls();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
